cva6_fence_flush_ctrl: RTL

// Sequencer for FENCE / FENCE.I / SFENCE.VMA in cores built on a write-back dcache (HPDcache WB).

---
 rtl/cva6_fence_flush_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cva6_fence_flush_ctrl.sv
// Fence sequencer: tracks in-flight stores, drains them on a fence,
// optionally flushes the dcache, then pulses the icache/TLB flush.
module cva6_fence_flush_ctrl #(
  parameter int unsigned NrStorePorts         = 1,
  parameter int unsigned MaxOutstandingStores = 7,
  parameter bit          FlushOnFence         = 1'b1,
  parameter bit          InvalidateOnFlush    = 1'b0,
  localparam int unsigned CW = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    fence_req_i,
  input  logic [1:0]              fence_type_i,
  output logic                    fence_ack_o,
  output logic                    busy_o,
  input  logic [NrStorePorts-1:0] st_issue_i,
  input  logic [NrStorePorts-1:0] st_ack_i,
  output logic                    st_stall_o,
  output logic [CW-1:0]           outstanding_o,
  output logic                    flush_req_o,
  output logic                    flush_inval_o,
  input  logic                    flush_ack_i,
  output logic                    icache_flush_o,
  output logic                    tlb_flush_o
);

  localparam int unsigned SW = CW + 2;

  localparam logic [1:0] FtFenceI = 2'b01;
  localparam logic [1:0] FtSfence = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    FLUSH = 3'd2,
    AUX   = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     type_q, type_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [SW-1:0]  iss_n, ack_n, sum_s, net_s;
  logic           is_fi, is_sf, do_flush, drained;

  assign is_fi    = (type_q == FtFenceI);
  assign is_sf    = (type_q == FtSfence);
  assign do_flush = is_fi | (~is_sf & FlushOnFence);
  assign drained  = (cnt_q == '0) & ~(|st_ack_i);

  // Store counter: issues add, acks subtract, clamped to the legal range.
  always_comb begin
    iss_n = SW'($countones(st_issue_i));
    ack_n = SW'($countones(st_ack_i));
    sum_s = SW'(cnt_q) + iss_n;
    net_s = sum_s - ack_n;
    cnt_d = '0;
    if (ack_n > sum_s) begin
      cnt_d = '0;
    end else if (net_s > SW'(MaxOutstandingStores)) begin
      cnt_d = CW'(MaxOutstandingStores);
    end else begin
      cnt_d = net_s[CW-1:0];
    end
  end

  // Fence sequencing: next state and latched fence type.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    unique case (state_q)
      IDLE: begin
        if (fence_req_i) begin
          type_d  = fence_type_i;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          if (do_flush) begin
            state_d = FLUSH;
          end else if (is_fi | is_sf) begin
            state_d = AUX;
          end else begin
            state_d = DONE;
          end
        end
      end
      FLUSH: begin
        if (flush_ack_i) begin
          state_d = is_fi ? AUX : DONE;
        end
      end
      AUX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, fence type and store count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      type_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign fence_ack_o    = (state_q == DONE);
  assign flush_req_o    = (state_q == FLUSH);
  assign flush_inval_o  = flush_req_o & InvalidateOnFlush;
  assign icache_flush_o = (state_q == AUX) & is_fi;
  assign tlb_flush_o    = (state_q == AUX) & is_sf;
  assign outstanding_o  = cnt_q;

  assign st_stall_o =
    (SW'(cnt_q) + SW'(NrStorePorts) > SW'(MaxOutstandingStores))
    | busy_o | fence_req_i;

`ifndef SYNTHESIS
  a_no_underflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    ack_n <= sum_s
  ) else $error("store ack underflow");

  a_no_issue_on_stall : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(st_stall_o && (|st_issue_i))
  ) else $error("store issued while stalled");
`endif

endmodule
